// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a req/ack
// handshake, and steers the next PC from branch/jump information from decode/execute.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [6:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  output logic        fetch_err
);

  // Memory handshake: imem_req is held high with a stable imem_addr for the
  // whole FETCH state. A transfer completes on any rising edge where both
  // imem_req and imem_ack are 1. imem_ack is ignored whenever imem_req is 0.

  localparam logic [31:0] NOP_INST      = 32'h0000_0013;
  localparam logic [7:0]  TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  timeout_cnt;
  logic [7:0]  timeout_cnt_next;
  logic [31:0] next_pc;
  logic        next_pc_misaligned;
  logic        load_inst;
  logic        load_pc;

  // Next-PC selection; jalr has highest priority, then jal, then a taken branch.
  always_comb begin
    next_pc = pc + 32'd4;
    if (jalr) begin
      next_pc = (rs1_data + imm) & ~32'h0000_0001;
    end else if (jal) begin
      next_pc = pc + imm;
    end else if (branch && zero) begin
      next_pc = pc + imm;
    end
  end

  assign next_pc_misaligned = |next_pc[1:0];

  always_comb begin
    state_next       = state;
    timeout_cnt_next = timeout_cnt;
    load_inst        = 1'b0;
    load_pc          = 1'b0;
    case (state)
      IDLE: begin
        state_next       = FETCH;
        timeout_cnt_next = 8'd0;
      end
      FETCH: begin
        if (imem_ack) begin
          load_inst        = 1'b1;
          timeout_cnt_next = 8'd0;
          state_next       = VALID;
        end else begin
          timeout_cnt_next = timeout_cnt + 8'd1;
          if (timeout_cnt + 8'd1 == TIMEOUT_LIMIT) begin
            state_next = ERROR;
          end
        end
      end
      VALID: begin
        // A misaligned target leaves pc pointing at the offending instruction.
        if (!stall) begin
          if (next_pc_misaligned) begin
            state_next = ERROR;
          end else begin
            load_pc    = 1'b1;
            state_next = FETCH;
          end
        end
      end
      ERROR: begin
        state_next = ERROR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      timeout_cnt <= 8'd0;
      pc          <= RESET_PC;
      inst        <= NOP_INST;
    end else begin
      state       <= state_next;
      timeout_cnt <= timeout_cnt_next;
      if (load_pc) begin
        pc <= next_pc;
      end
      if (load_inst) begin
        inst <= imem_rdata;
      end
    end
  end

  assign imem_req   = (state == FETCH);
  assign imem_addr  = pc;
  assign opcode     = inst[6:0];
  assign pc_plus4   = pc + 32'd4;
  assign inst_valid = (state == VALID);
  assign fetch_err  = (state == ERROR);

endmodule
